// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared constants and types for the fetch-to-decode instruction queue.
//   RESET_PC / NOP_INSTR are what the head outputs show whenever the queue
//   is empty, so decode sees a harmless NOP at the boot PC.
package fetch_queue_pkg;

  localparam int          DEPTH_DEFAULT = 4;
  localparam logic [31:0] RESET_PC      = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

  // One queue slot: the fetched PC together with its instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the fetch-side push port, the decode-side pop port and the
//   control-redirect flush into one interface.
//   Ports (signals):
//     in_valid, in_PC, in_instr : fetch presents a PC/instruction pair
//     full                      : queue full, fetch enable = ~full
//     out_ready                 : decode accepts the head entry
//     flush                     : discard every queued entry
//     out_valid, out_PC, out_PC4, out_instr : head entry presented to decode
//     count                     : number of valid entries, 0..DEPTH
//   modport slave  : the queue itself
//   modport master : the surrounding pipeline (fetch, decode, redirect)
interface fetch_queue_if #(
  parameter int AW = 2
);

  logic        in_valid;
  logic [31:0] in_PC;
  logic [31:0] in_instr;
  logic        full;
  logic        out_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_PC;
  logic [31:0] out_PC4;
  logic [31:0] out_instr;
  logic [AW:0] count;

  modport slave (
    input  in_valid, in_PC, in_instr, out_ready, flush,
    output full, out_valid, out_PC, out_PC4, out_instr, count
  );

  modport master (
    output in_valid, in_PC, in_instr, out_ready, flush,
    input  full, out_valid, out_PC, out_PC4, out_instr, count
  );

endinterface

// File: rtl/fq_ptr.sv
// fq_ptr
//   AW-bit modulo-2**AW pointer with synchronous reset, synchronous clear
//   and increment enable. Used for both the write and the read pointer.
//   Ports:
//     clk   : clock
//     reset : synchronous active-high reset (ptr -> 0)
//     clear : synchronous clear (ptr -> 0), same effect as reset
//     inc   : advance the pointer by one
//     ptr   : current pointer value
module fq_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      // Queue depth is a power of two, so natural overflow is the wrap.
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   In-order instruction queue between fetch and decode. Each accepted
//   {PC, instr} pair is written at the tail; decode sees the oldest entry
//   at the head. Fetch keeps filling while decode stalls, until full.
//   A flush empties the queue; reset has priority over flush.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     reset : synchronous active-high reset
//     q     : fetch_queue_if.slave (push, pop, flush, status, head entry)
//   Parameters:
//     DEPTH : number of entries (power of two, >= 2)
//     AW    : log2(DEPTH); must match the AW of the connected interface
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.slave q
);

  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  fq_entry_t         mem [DEPTH];
  fq_entry_t         head;
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [AW:0]       cnt;
  logic              push;
  logic              pop;
  logic [31:0]       head_pc;

  // full and out_valid come only from the cnt register, so there is no
  // combinational path from out_ready (or in_valid) back to full.
  assign q.full      = (cnt == CNT_FULL);
  assign q.out_valid = (cnt != '0);
  assign q.count     = cnt;

  // A push is refused while full even if decode pops the same cycle;
  // a flush discards any same-cycle push or pop.
  assign push = q.in_valid  && !q.full && !q.flush;
  assign pop  = q.out_valid && q.out_ready && !q.flush;

  fq_ptr #(.AW(AW)) u_wp (
    .clk   (clk),
    .reset (reset),
    .clear (q.flush),
    .inc   (push),
    .ptr   (wp)
  );

  fq_ptr #(.AW(AW)) u_rp (
    .clk   (clk),
    .reset (reset),
    .clear (q.flush),
    .inc   (pop),
    .ptr   (rp)
  );

  // NOTE: the storage array carries no reset; cnt alone decides which
  // slots are meaningful, so its contents are never observed stale.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= '{pc: q.in_PC, instr: q.in_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head is read straight from storage; no bypass from in_* exists, so a
  // pushed entry is visible no earlier than the cycle after its push.
  assign head        = mem[rp];
  assign head_pc     = q.out_valid ? head.pc : RESET_PC;
  assign q.out_PC    = head_pc;
  assign q.out_PC4   = head_pc + 32'd4;
  assign q.out_instr = q.out_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Self-checking bench for fetch_queue: directed scenarios followed by
//   randomized traffic, all compared against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_queue_if #(.AW(AW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  ent_t model[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  // Compare every DUT output against what the model says the queue holds.
  task automatic check_outputs();
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
    logic [31:0] exp_in;
    if (model.size() == 0) begin
      exp_pc = RESET_PC;
      exp_in = NOP_INSTR;
    end else begin
      exp_pc = model[0].pc;
      exp_in = model[0].instr;
    end
    exp_pc4 = exp_pc + 32'd4;
    check("out_valid", 64'(bus.out_valid), 64'(model.size() != 0));
    check("full",      64'(bus.full),      64'(model.size() == DEPTH));
    check("count",     64'(bus.count),     64'(model.size()));
    check("out_PC",    64'(bus.out_PC),    64'(exp_pc));
    check("out_PC4",   64'(bus.out_PC4),   64'(exp_pc4));
    check("out_instr", 64'(bus.out_instr), 64'(exp_in));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check
  // the outputs half a cycle later.
  task automatic cycle(input bit rst, input bit iv, input logic [31:0] pc,
                       input logic [31:0] ins, input bit rdy, input bit fl);
    bit do_push;
    bit do_pop;
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_PC     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(posedge clk);
    do_push = iv  && (model.size() < DEPTH) && !fl;
    do_pop  = rdy && (model.size() != 0)    && !fl;
    if (rst || fl) begin
      model.delete();
    end else begin
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back('{pc: pc, instr: ins});
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic push_pc(input logic [31:0] pc, input bit rdy);
    cycle(1'b0, 1'b1, pc, instr_of(pc), rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_PC     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset held two cycles.
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Basic flow with decode always ready.
    push_pc(32'h3000, 1'b1);
    push_pc(32'h3004, 1'b1);
    push_pc(32'h3008, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill while decode stalls; the fifth push is refused.
    push_pc(32'h3000, 1'b0);
    push_pc(32'h3004, 1'b0);
    push_pc(32'h3008, 1'b0);
    push_pc(32'h300C, 1'b0);
    push_pc(32'h3010, 1'b0);
    idle(1'b0);

    // Drain from full across pointer wrap while fetch keeps offering.
    push_pc(32'h3010, 1'b1);
    push_pc(32'h3010, 1'b1);
    push_pc(32'h3014, 1'b1);
    repeat (6) idle(1'b1);

    // Simultaneous push and pop at count 2.
    push_pc(32'h5000, 1'b0);
    push_pc(32'h5004, 1'b0);
    push_pc(32'h5008, 1'b1);
    push_pc(32'h500C, 1'b0);

    // Flush with 3 queued and a same-cycle push of 0x4000.
    cycle(1'b0, 1'b1, 32'h4000, instr_of(32'h4000), 1'b0, 1'b1);
    idle(1'b0);
    push_pc(32'h4000, 1'b0);
    idle(1'b1);

    // Reset while full.
    push_pc(32'h6000, 1'b0);
    push_pc(32'h6004, 1'b0);
    push_pc(32'h6008, 1'b0);
    push_pc(32'h600C, 1'b0);
    cycle(1'b1, 1'b1, 32'h6010, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle(1'b0);

    // Randomized traffic; ready probability varies by phase so the queue
    // spends time both near empty and near full. PCs include values near
    // 0xFFFFFFFC to exercise the PC+4 wrap.
    for (int i = 0; i < 1600; i++) begin
      int          rdy_pct;
      bit          rst;
      bit          fl;
      bit          iv;
      bit          rdy;
      logic [31:0] pc;
      rdy_pct = ((i / 200) % 2 == 0) ? 25 : 80;
      rst     = ($urandom_range(0, 149) == 0);
      fl      = ($urandom_range(0, 39) == 0);
      iv      = ($urandom_range(0, 3) != 0);
      rdy     = ($urandom_range(0, 99) < rdy_pct);
      pc      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      cycle(rst, iv, pc, $urandom, rdy, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
